mod_exp_ctrl: RTL and testbench

Sequencer for a single Montgomery multiplier that computes a modular exponentiation result = x^e mod m, the core RSA operation. It uses left-to-right square-and-multiply in the Montgomery domain and finishes with one conversion multiply by 1. The multiplier is a separate instance driven through this block's mm_* ports, so the block only schedules work and holds the accumulator. The block sits between the top-level RSA command interface and the multiplier.

---
 rtl/mod_exp_pkg.sv | 22 ++
 rtl/mod_exp_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mod_exp_pkg.sv
// Purpose: shared definitions for the modular-exponentiation sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mod_exp_pkg;

    // Default operand width; ONE_N is sized to it and cast to the instance width.
    localparam int unsigned N_DEF = 512;
    localparam logic [N_DEF-1:0] ONE_N = N_DEF'(1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CHECK     = 4'd1,
        S_SQ_ISSUE  = 4'd2,
        S_SQ_WAIT   = 4'd3,
        S_MUL_ISSUE = 4'd4,
        S_MUL_WAIT  = 4'd5,
        S_FINAL     = 4'd6,
        S_FIN_WAIT  = 4'd7,
        S_DONE      = 4'd8
    } state_e;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Purpose: schedules left-to-right square-and-multiply on one external Montgomery multiplier.
// Latency: start-to-done = 1 + per scanned bit (CHECK + issue + wait per multiply) + final multiply + 1.
// Backpressure: none; one multiply outstanding, each issue waits for mm_done before the next.
//
// Ports: clk/resetn (async, active-high despite the name); start + in_x/in_r/in_e/in_elen/in_m
// command inputs; busy/done/result/mult_count status; mm_start/mm_a/mm_b/mm_m issue to the
// multiplier, mm_result/mm_done completion from it.
module mod_exp_ctrl
    import mod_exp_pkg::*;
#(
    parameter int unsigned N      = 512,
    parameter int unsigned ELEN_W = 10
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [N-1:0]        in_x,
    input  logic [N-1:0]        in_r,
    input  logic [N-1:0]        in_e,
    input  logic [ELEN_W-1:0]   in_elen,
    input  logic [N-1:0]        in_m,
    output logic                busy,
    output logic                done,
    output logic [N-1:0]        result,
    output logic [ELEN_W+1:0]   mult_count,
    output logic                mm_start,
    output logic [N-1:0]        mm_a,
    output logic [N-1:0]        mm_b,
    output logic [N-1:0]        mm_m,
    input  logic [N-1:0]        mm_result,
    input  logic                mm_done
);

    localparam int unsigned CNT_W = ELEN_W + 2;
    localparam logic [N-1:0]      ONE     = N'(ONE_N);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ELEN_W-1:0] IDX_ONE = ELEN_W'(1);

    state_e             state_q, state_d;
    logic [N-1:0]       acc_q, acc_d;
    logic [N-1:0]       x_q, x_d;
    logic [N-1:0]       e_q, e_d;
    logic [ELEN_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       result_q, result_d;
    logic               mm_start_q, mm_start_d;
    logic [N-1:0]       mm_a_q, mm_a_d;
    logic [N-1:0]       mm_b_q, mm_b_d;
    logic [N-1:0]       mm_m_q, mm_m_d;

    // Variable shift instead of e_q[idx_q]: keeps the select legal for any idx width
    // and yields 0 for an out-of-range index rather than X.
    logic [N-1:0] e_shift;
    logic         e_bit;
    assign e_shift = e_q >> idx_q;
    assign e_bit   = e_shift[0];

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            x_q        <= '0;
            e_q        <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_m_q     <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            e_q        <= e_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            mm_start_q <= mm_start_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            mm_m_q     <= mm_m_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        x_d        = x_q;
        e_d        = e_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        mm_start_d = 1'b0;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        mm_m_d     = mm_m_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = in_x;
                    e_d     = in_e;
                    mm_m_d  = in_m;
                    acc_d   = in_r;     // Montgomery form of 1
                    idx_d   = in_elen;
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (idx_q == '0) begin
                    state_d = S_FINAL;
                end else begin
                    idx_d   = idx_q - IDX_ONE;
                    state_d = S_SQ_ISSUE;
                end
            end
            S_SQ_ISSUE: begin
                mm_a_d     = acc_q;
                mm_b_d     = acc_q;
                mm_start_d = 1'b1;
                cnt_d      = cnt_q + CNT_ONE;
                state_d    = S_SQ_WAIT;
            end
            S_SQ_WAIT: begin
                if (mm_done) begin
                    acc_d   = mm_result;
                    state_d = e_bit ? S_MUL_ISSUE : S_CHECK;
                end
            end
            S_MUL_ISSUE: begin
                mm_a_d     = acc_q;
                mm_b_d     = x_q;
                mm_start_d = 1'b1;
                cnt_d      = cnt_q + CNT_ONE;
                state_d    = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (mm_done) begin
                    acc_d   = mm_result;
                    state_d = S_CHECK;
                end
            end
            S_FINAL: begin
                // Multiply by plain 1 strips the R factor, leaving the normal-domain value.
                mm_a_d     = acc_q;
                mm_b_d     = ONE;
                mm_start_d = 1'b1;
                cnt_d      = cnt_q + CNT_ONE;
                state_d    = S_FIN_WAIT;
            end
            S_FIN_WAIT: begin
                if (mm_done) begin
                    result_d = mm_result;
                    state_d  = S_DONE;
                end
            end
            // One-cycle done state: a start coinciding with done lands here and is dropped.
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign result     = result_q;
    assign mult_count = cnt_q;
    assign mm_start   = mm_start_q;
    assign mm_a       = mm_a_q;
    assign mm_b       = mm_b_q;
    assign mm_m       = mm_m_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Purpose: directed bench for mod_exp_ctrl with a latency-programmable Montgomery model.
// Latency: model latency set per run (1, 3, 20 cycles).
// Backpressure: n/a.
module tb_mod_exp_ctrl;

    localparam int N      = 8;
    localparam int ELEN_W = 4;
    localparam int MOD    = 13;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic              start = 1'b0;
    logic [N-1:0]      in_x = 8'd5;    // 2 * 256 mod 13
    logic [N-1:0]      in_r = 8'd9;    // 256 mod 13
    logic [N-1:0]      in_e = '0;
    logic [ELEN_W-1:0] in_elen = '0;
    logic [N-1:0]      in_m = 8'd13;
    logic              busy, done, mm_start;
    logic [N-1:0]      result, mm_a, mm_b, mm_m;
    logic [ELEN_W+1:0] mult_count;
    logic [N-1:0]      mm_result = '0;
    logic              mm_done = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    mod_exp_ctrl #(.N(N), .ELEN_W(ELEN_W)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_r(in_r), .in_e(in_e), .in_elen(in_elen), .in_m(in_m),
        .busy(busy), .done(done), .result(result), .mult_count(mult_count),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // Behavioural Montgomery multiplier: a*b*R^-1 mod m, R = 256.
    int rinv = 0;
    int lat_cfg = 3;
    int cnt_m = 0;
    logic pend = 1'b0;
    int ca = 0, cb = 0, cm = 1;

    initial begin
        for (int i = 1; i < MOD; i++) if (((256 * i) % MOD) == 1) rinv = i;
    end

    always @(posedge clk) begin
        mm_done <= 1'b0;
        if (resetn) begin
            pend <= 1'b0;
        end else if (pend) begin
            if (cnt_m <= 1) begin
                mm_done   <= 1'b1;
                mm_result <= N'((ca * cb * rinv) % cm);
                pend      <= 1'b0;
            end else begin
                cnt_m <= cnt_m - 1;
            end
        end else if (mm_start) begin
            pend  <= 1'b1;
            cnt_m <= lat_cfg;
            ca    <= int'(mm_a);
            cb    <= int'(mm_b);
            cm    <= int'(mm_m);
        end
    end

    // Protocol monitor: no overlapping issue, operands stable while outstanding.
    int proto_err = 0;
    int done_cnt = 0;
    logic outst = 1'b0;
    logic [N-1:0] pa = '0, pb = '0, pm = '0;

    always @(posedge clk) begin
        if (done) done_cnt++;
        if (resetn) begin
            outst <= 1'b0;
        end else begin
            if (mm_start) begin
                if (outst) proto_err++;
                outst <= 1'b1;
                pa <= mm_a; pb <= mm_b; pm <= mm_m;
            end else if (outst && (mm_a !== pa || mm_b !== pb || mm_m !== pm)) begin
                proto_err++;
            end
            if (mm_done) outst <= 1'b0;
        end
    end

    task automatic pulse_start(input logic [N-1:0] e, input logic [ELEN_W-1:0] elen);
        in_e = e;
        in_elen = elen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_no_timeout"}, 64'(n < 3000), 64'd1);
    endtask

    task automatic wait_count(input string tag, input int v);
        int n = 0;
        while (int'(mult_count) != v && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reach_count"}, 64'(n < 3000), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] e, input logic [ELEN_W-1:0] elen,
                          input int lat, input int exp_res, input int exp_cnt);
        int d0;
        lat_cfg = lat;
        d0 = done_cnt;
        pulse_start(e, elen);
        chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        wait_done(tag);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_result"}, 64'(result), 64'(exp_res));
        chk({tag, "_mult_count"}, 64'(mult_count), 64'(exp_cnt));
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_count", 64'(mult_count), 64'd0);
        chk("rst_mm_start", 64'(mm_start), 64'd0);
        resetn = 1'b0;
        @(negedge clk);

        // 2^5 mod 13 = 6; 3 squares + 2 multiplies + final
        run_op("e5", 8'd5, 4'd3, 3, 6, 6);
        // empty exponent: only the conversion multiply
        run_op("e0", 8'd0, 4'd0, 3, 1, 1);
        // 2^255 = 2^(12*21+3) -> 8 mod 13; 8 + 8 + 1 multiplies
        run_op("eff_l3", 8'hFF, 4'd8, 3, 8, 17);
        run_op("eff_l1", 8'hFF, 4'd8, 1, 8, 17);
        run_op("eff_l20", 8'hFF, 4'd8, 20, 8, 17);
        // bits above e_len ignored: 0xF5 with e_len 3 behaves as 5
        run_op("e_hi_ignored", 8'hF5, 4'd3, 2, 6, 6);

        // Starts during SQ_WAIT and coincident with done are dropped
        lat_cfg = 3;
        pulse_start(8'd5, 4'd3);
        wait_count("ign", 1);
        @(negedge clk);
        pulse_start(8'd0, 4'd0);
        wait_done("ign");
        start = 1'b1;
        in_e = 8'd0;
        in_elen = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy_after_done_start", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("ign_busy_idle", 64'(busy), 64'd0);
        chk("ign_result", 64'(result), 64'd6);
        chk("ign_count", 64'(mult_count), 64'd6);
        run_op("after_ign", 8'd0, 4'd0, 3, 1, 1);

        // Reset in the middle of MUL_WAIT (2nd multiply of e=5 is a MUL)
        lat_cfg = 20;
        pulse_start(8'd5, 4'd3);
        wait_count("mid", 2);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_count", 64'(mult_count), 64'd0);
        chk("mid_rst_mm_start", 64'(mm_start), 64'd0);
        chk("mid_rst_mm_a", 64'(mm_a), 64'd0);
        chk("mid_rst_mm_b", 64'(mm_b), 64'd0);
        chk("mid_rst_mm_m", 64'(mm_m), 64'd0);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        run_op("post_rst", 8'd5, 4'd3, 3, 6, 6);

        chk("protocol", 64'(proto_err), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
